mem_fetch_unit: RTL and testbench

- Memory-side datapath stage driven directly by the control unit's strobes.
- Holds PC, MAR, MBR, IR and the unified program/data RAM.
- Produces IR_out, which feeds the control unit's CU_in, and MBR_out, which is the LD data to the register file.
- Accepts store data from the register file.
- Provides a preload port so programs can be written into RAM before execution.

---
 rtl/mem_pkg.sv | 19 +
 rtl/mem_fetch_unit_if.sv | 39 +++
 rtl/mem_fetch_unit_ram_sp.sv | 27 ++
 rtl/mem_fetch_unit.sv | 113 +++++++++++
 tb/tb_mem_fetch_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants and mux encodings for the memory fetch stage
// Contents: data-path widths, reset PC, LD/ST data page base, MAR/MBR source codes.
package mem_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [7:0] RESET_PC  = 8'h00;
  localparam logic [7:0] DATA_BASE = 8'hF0;

  // MAR_mux encodings
  localparam logic MAR_SRC_PC = 1'b0;
  localparam logic MAR_SRC_IR = 1'b1;

  // MBR_mux encodings
  localparam logic MBR_SRC_RAM = 1'b0;
  localparam logic MBR_SRC_RF  = 1'b1;

endpackage

// File: rtl/mem_fetch_unit_if.sv
// rtl/mem_fetch_unit_if.sv - control-unit strobe and data bus of the memory fetch stage
// master: control unit / preload side drives strobes, RF data and preload port,
//         observes IR_out, MBR_out, PC_out, MAR_out, Mem_fault.
// slave:  mem_fetch_unit, the mirror image.
interface mem_fetch_unit_if #(
  parameter int ADDR_W = mem_pkg::ADDR_W,
  parameter int DATA_W = mem_pkg::DATA_W
);

  logic              MAR_we;
  logic              MAR_mux;
  logic              MBR_we;
  logic              MBR_mux;
  logic              IR_we;
  logic              PC_inc;
  logic              RAM_we;
  logic [DATA_W-1:0] RF_data_in;
  logic              Load_en;
  logic [ADDR_W-1:0] Load_addr;
  logic [DATA_W-1:0] Load_data;
  logic [DATA_W-1:0] IR_out;
  logic [DATA_W-1:0] MBR_out;
  logic [ADDR_W-1:0] PC_out;
  logic [ADDR_W-1:0] MAR_out;
  logic              Mem_fault;

  modport master (
    output MAR_we, MAR_mux, MBR_we, MBR_mux, IR_we, PC_inc, RAM_we,
    output RF_data_in, Load_en, Load_addr, Load_data,
    input  IR_out, MBR_out, PC_out, MAR_out, Mem_fault
  );

  modport slave (
    input  MAR_we, MAR_mux, MBR_we, MBR_mux, IR_we, PC_inc, RAM_we,
    input  RF_data_in, Load_en, Load_addr, Load_data,
    output IR_out, MBR_out, PC_out, MAR_out, Mem_fault
  );

endinterface

// File: rtl/mem_fetch_unit_ram_sp.sv
// rtl/mem_fetch_unit_ram_sp.sv - single-port RAM, synchronous write, asynchronous read
// Ports: clk_i, we_i, waddr_i, wdata_i (write port); raddr_i -> rdata_o (combinational).
// No reset: contents survive the stage reset.
module ram_sp #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_fetch_unit.sv
// rtl/mem_fetch_unit.sv - PC/MAR/MBR/IR registers and unified RAM driven by CU strobes
// Ports: MEM_clk, MEM_rst (sync, active-high); bus (mem_fetch_unit_if.slave) carrying
//        CU strobes, RF store data, preload port and the register outputs.
// Build option: MEM_PROTECT_EN blocks CU writes below DATA_BASE and raises sticky Mem_fault.
module mem_fetch_unit
  import mem_pkg::*;
#(
  parameter int                ADDR_W    = mem_pkg::ADDR_W,
  parameter int                DATA_W    = mem_pkg::DATA_W,
  parameter int                RAM_DEPTH = 2 ** ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(mem_pkg::RESET_PC),
  parameter logic [ADDR_W-1:0] DATA_BASE = ADDR_W'(mem_pkg::DATA_BASE)
) (
  input  logic            MEM_clk,
  input  logic            MEM_rst,
  mem_fetch_unit_if.slave bus
);

  logic [ADDR_W-1:0] pc_q,  pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mbr_q, mbr_d;
  logic [DATA_W-1:0] ir_q,  ir_d;

  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              wr_blocked;
  logic [ADDR_W-1:0] data_ea;

  // LD/ST effective address: low nibble of the instruction within the data page
  assign data_ea = DATA_BASE | ADDR_W'(ir_q[3:0]);

`ifdef MEM_PROTECT_EN
  logic fault_q;

  assign wr_blocked = bus.RAM_we && (mar_q < DATA_BASE);

  // Preload cycles ignore RAM_we entirely, so they can neither write nor fault
  always_ff @(posedge MEM_clk) begin
    if (MEM_rst) begin
      fault_q <= 1'b0;
    end else if (!bus.Load_en && wr_blocked) begin
      fault_q <= 1'b1;
    end
  end

  assign bus.Mem_fault = fault_q;
`else
  assign wr_blocked    = 1'b0;
  assign bus.Mem_fault = 1'b0;
`endif

  // Preload owns the write port when active; reset suppresses every write
  assign ram_we    = !MEM_rst && (bus.Load_en || (bus.RAM_we && !wr_blocked));
  assign ram_waddr = bus.Load_en ? bus.Load_addr : mar_q;
  assign ram_wdata = bus.Load_en ? bus.Load_data : mbr_q;

  ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (RAM_DEPTH)
  ) u_ram (
    .clk_i   (MEM_clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i (mar_q),
    .rdata_o (ram_rdata)
  );

  // All strobes read pre-edge register values, so simultaneous strobes see old state
  always_comb begin
    pc_d  = pc_q;
    mar_d = mar_q;
    mbr_d = mbr_q;
    ir_d  = ir_q;
    if (!bus.Load_en) begin
      if (bus.MAR_we) begin
        mar_d = (bus.MAR_mux == MAR_SRC_IR) ? data_ea : pc_q;
      end
      if (bus.MBR_we) begin
        mbr_d = (bus.MBR_mux == MBR_SRC_RF) ? bus.RF_data_in : ram_rdata;
      end
      if (bus.IR_we) begin
        ir_d = mbr_q;
      end
      if (bus.PC_inc) begin
        pc_d = pc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge MEM_clk) begin
    if (MEM_rst) begin
      pc_q  <= RESET_PC;
      mar_q <= '0;
      mbr_q <= '0;
      ir_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      mar_q <= mar_d;
      mbr_q <= mbr_d;
      ir_q  <= ir_d;
    end
  end

  assign bus.IR_out  = ir_q;
  assign bus.MBR_out = mbr_q;
  assign bus.PC_out  = pc_q;
  assign bus.MAR_out = mar_q;

endmodule

// File: tb/tb_mem_fetch_unit.sv
// tb/tb_mem_fetch_unit.sv - scoreboard bench for mem_fetch_unit
module tb_mem_fetch_unit;

  localparam int O_IR = 0, O_MBR = 1, O_PC = 2, O_MAR = 3, O_FAULT = 4;

  typedef struct {
    string      tag;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  mem_fetch_unit_if bus ();

  mem_fetch_unit dut (
    .MEM_clk (clk),
    .MEM_rst (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      O_IR:    return bus.IR_out;
      O_MBR:   return bus.MBR_out;
      O_PC:    return bus.PC_out;
      O_MAR:   return bus.MAR_out;
      default: return {7'd0, bus.Mem_fault};
    endcase
  endfunction

  task automatic expect_val(input string tag, input int sel, input logic [7:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    exp_q.push_back(e);
  endtask

  // One active edge; outputs sampled 1 time unit later, then pending expectations drained
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, observe(e.sel), e.exp);
    end
  endtask

  task automatic idle();
    bus.MAR_we = 0; bus.MAR_mux = 0; bus.MBR_we = 0; bus.MBR_mux = 0;
    bus.IR_we = 0; bus.PC_inc = 0; bus.RAM_we = 0; bus.Load_en = 0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    bus.Load_en = 1; bus.Load_addr = a; bus.Load_data = d;
    step();
    bus.Load_en = 0;
  endtask

  task automatic fetch(input string tag, input logic [7:0] exp_ir, input logic [7:0] exp_pc);
    idle(); bus.MAR_we = 1;
    step();
    idle(); bus.MBR_we = 1; bus.PC_inc = 1;
    step();
    idle(); bus.IR_we = 1;
    expect_val({tag, "_ir"}, O_IR, exp_ir);
    expect_val({tag, "_pc"}, O_PC, exp_pc);
    step();
    idle();
  endtask

  task automatic load_data(input string tag, input logic [7:0] exp_mar, input logic [7:0] exp_mbr);
    idle(); bus.MAR_we = 1; bus.MAR_mux = 1;
    expect_val({tag, "_mar"}, O_MAR, exp_mar);
    step();
    idle(); bus.MBR_we = 1;
    expect_val({tag, "_mbr"}, O_MBR, exp_mbr);
    step();
    idle();
  endtask

  initial begin
    logic [7:0] exp_prot_ram;
    logic [7:0] exp_prot_fault;
`ifdef MEM_PROTECT_EN
    exp_prot_ram   = 8'h5A;
    exp_prot_fault = 8'h01;
`else
    exp_prot_ram   = 8'hEE;
    exp_prot_fault = 8'h00;
`endif
    idle();
    bus.RF_data_in = 8'h00; bus.Load_addr = 8'h00; bus.Load_data = 8'h00;

    // Reset overrides strobes, including preload
    rst = 1; bus.PC_inc = 1; bus.MAR_we = 1;
    expect_val("rst_pc", O_PC, 8'h00);
    expect_val("rst_mar", O_MAR, 8'h00);
    expect_val("rst_mbr", O_MBR, 8'h00);
    expect_val("rst_ir", O_IR, 8'h00);
    expect_val("rst_fault", O_FAULT, 8'h00);
    step();
    idle();

    // Program and data preload
    rst = 0;
    preload(8'h00, 8'h3A);
    preload(8'h01, 8'h25);
    preload(8'h02, 8'h07);
    preload(8'h03, 8'h13);
    preload(8'hF7, 8'h5C);
    preload(8'hF3, 8'h00);
    preload(8'h10, 8'h5A);
    rst = 1; step(); rst = 0;

    fetch("fetch0", 8'h3A, 8'h01);
    fetch("fetch1", 8'h25, 8'h02);
    fetch("fetch2", 8'h07, 8'h03);
    load_data("ld_f7", 8'hF7, 8'h5C);

    // ST to F3, then read back with a LD
    fetch("fetch3", 8'h13, 8'h04);
    bus.RF_data_in = 8'hA5;
    idle(); bus.MAR_we = 1; bus.MAR_mux = 1;
    step();
    idle(); bus.MBR_we = 1; bus.MBR_mux = 1;
    step();
    idle(); bus.RAM_we = 1;
    step();
    idle(); bus.MBR_we = 1; bus.MBR_mux = 1; bus.RF_data_in = 8'h00;
    expect_val("st_clr_mbr", O_MBR, 8'h00);
    step();
    load_data("st_ld", 8'hF3, 8'hA5);

    // PC wraparound, then MAR_we + PC_inc sees old PC
    bus.PC_inc = 1;
    for (int i = 0; i < 250; i++) step();
    expect_val("pc_ff", O_PC, 8'hFF);
    step();
    expect_val("pc_wrap", O_PC, 8'h00);
    step();
    bus.MAR_we = 1; bus.MAR_mux = 0;
    expect_val("mar_old_pc", O_MAR, 8'h00);
    expect_val("pc_after", O_PC, 8'h01);
    step();
    idle();

    // Preload with every strobe high: registers hold
    bus.MAR_we = 1; bus.MAR_mux = 1; bus.MBR_we = 1; bus.MBR_mux = 1;
    bus.IR_we = 1; bus.PC_inc = 1; bus.RF_data_in = 8'hFF;
    bus.Load_en = 1; bus.Load_addr = 8'h00; bus.Load_data = 8'h22;
    expect_val("pl_pc", O_PC, 8'h01);
    expect_val("pl_mar", O_MAR, 8'h00);
    expect_val("pl_mbr", O_MBR, 8'hA5);
    expect_val("pl_ir", O_IR, 8'h13);
    step();
    idle();

    // MBR_we + IR_we together: IR takes old MBR
    bus.MBR_we = 1; bus.MBR_mux = 1; bus.RF_data_in = 8'h11;
    step();
    idle(); bus.MBR_we = 1; bus.MBR_mux = 0; bus.IR_we = 1;
    expect_val("par_ir", O_IR, 8'h11);
    expect_val("par_mbr", O_MBR, 8'h22);
    step();
    idle();

    // Reset mid-fetch, RAM retained
    bus.MAR_we = 1;
    step();
    idle(); bus.MBR_we = 1; bus.PC_inc = 1;
    step();
    idle(); bus.IR_we = 1; rst = 1;
    expect_val("mid_pc", O_PC, 8'h00);
    expect_val("mid_mar", O_MAR, 8'h00);
    expect_val("mid_mbr", O_MBR, 8'h00);
    expect_val("mid_ir", O_IR, 8'h00);
    step();
    rst = 0; idle();
    fetch("refetch", 8'h22, 8'h01);

    // Write below the data page
    bus.PC_inc = 1;
    for (int i = 0; i < 15; i++) step();
    idle(); bus.MAR_we = 1;
    expect_val("prot_mar", O_MAR, 8'h10);
    step();
    idle(); bus.MBR_we = 1; bus.MBR_mux = 1; bus.RF_data_in = 8'hEE;
    step();
    idle(); bus.RAM_we = 1;
    expect_val("prot_fault", O_FAULT, exp_prot_fault);
    step();
    idle(); bus.MBR_we = 1;
    expect_val("prot_ram", O_MBR, exp_prot_ram);
    expect_val("prot_sticky", O_FAULT, exp_prot_fault);
    step();
    idle(); rst = 1;
    expect_val("prot_clr", O_FAULT, 8'h00);
    step();
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
